// File: rtl/dff_pipe.sv
// dff_pipe: DEPTH-stage, WIDTH-bit valid/ready register pipeline with bubble collapse,
// synchronous flush and a registered occupancy count.
module dff_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(DEPTH+1)-1:0] occupancy
);
    localparam int OW = $clog2(DEPTH+1);

    logic [DEPTH-1:0] valid, rdy, prev_valid, next_valid;
    logic [WIDTH-1:0] data [DEPTH];
    logic [WIDTH-1:0] prev_data [DEPTH];
    logic [OW-1:0]    next_occ;

    // A stage is ready when it or any stage downstream of it is empty, or the sink accepts.
    always_comb begin
        rdy = '0;
        for (int i = 0; i < DEPTH; i++) begin
            rdy[i] = out_ready;
            for (int j = i; j < DEPTH; j++) rdy[i] = rdy[i] | ~valid[j];
        end
    end

    always_comb begin
        prev_valid[0] = in_valid;
        prev_data[0]  = in_data;
        for (int i = 1; i < DEPTH; i++) begin
            prev_valid[i] = valid[i-1];
            prev_data[i]  = data[i-1];
        end
        next_valid = '0;
        next_occ   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            next_valid[i] = rdy[i] ? prev_valid[i] : valid[i];
            next_occ      = next_occ + OW'(next_valid[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
        end else if (flush) begin
            valid     <= '0;
            occupancy <= '0;
            for (int i = 0; i < DEPTH; i++) data[i] <= RESET_VAL;
        end else begin
            valid     <= next_valid;
            occupancy <= next_occ;
            for (int i = 0; i < DEPTH; i++)
                if (rdy[i] && prev_valid[i]) data[i] <= prev_data[i];
        end
    end

    assign in_ready  = rdy[0] && !flush && !rst;
    assign out_valid = valid[DEPTH-1];
    assign out_data  = data[DEPTH-1];
endmodule

// File: tb/tb_dff_pipe.sv
// tb_dff_pipe: table-driven and scoreboard checks of dff_pipe (WIDTH=8, DEPTH=3).
module tb_dff_pipe;
    localparam int W = 8;
    localparam int D = 3;

    logic         clk = 0, rst = 1, flush = 0, in_valid = 0, out_ready = 0;
    logic [W-1:0] in_data = '0;
    logic         in_ready, out_valid;
    logic [W-1:0] out_data;
    logic [1:0]   occupancy;

    int           ncmp = 0, nerr = 0;
    logic [W-1:0] q [$];

    typedef struct {
        logic       iv;
        logic [7:0] id;
        logic       ordy;
        logic       fl;
        logic       e_ir;
        logic       e_ov;
        int         e_occ;
        logic [7:0] e_od;
    } vec_t;
    vec_t tbl [$];

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(W), .DEPTH(D), .RESET_VAL(8'h00)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .occupancy(occupancy)
    );

    task automatic chk(input string name, input int act, input int exp);
        ncmp++;
        if (act != exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: score handshakes visible before the edge, then advance past it.
    task automatic step();
        logic up, dn, fl;
        #1;
        up = in_valid && in_ready;
        dn = out_valid && out_ready;
        fl = flush;
        if (dn) begin
            if (q.size() == 0) begin
                ncmp++;
                nerr++;
                $display("FAIL sb_unexpected: got %0h expected no output", out_data);
            end else chk("sb_data", out_data, q.pop_front());
        end
        if (up) q.push_back(in_data);
        @(posedge clk);
        if (fl) q.delete();
        #1;
    endtask

    function automatic void add(input logic iv, input logic [7:0] id, input logic ordy, input logic fl,
                                input logic e_ir, input logic e_ov, input int e_occ, input logic [7:0] e_od);
        tbl.push_back('{iv, id, ordy, fl, e_ir, e_ov, e_occ, e_od});
    endfunction

    task automatic run_table(input string tag);
        for (int i = 0; i < tbl.size(); i++) begin
            in_valid  = tbl[i].iv;
            in_data   = tbl[i].id;
            out_ready = tbl[i].ordy;
            flush     = tbl[i].fl;
            #1;
            chk($sformatf("%s%0d_in_ready", tag, i), in_ready, tbl[i].e_ir);
            chk($sformatf("%s%0d_out_valid", tag, i), out_valid, tbl[i].e_ov);
            chk($sformatf("%s%0d_occupancy", tag, i), occupancy, tbl[i].e_occ);
            if (tbl[i].e_ov) chk($sformatf("%s%0d_out_data", tag, i), out_data, tbl[i].e_od);
            step();
        end
        flush = 0;
        tbl.delete();
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_in_ready", in_ready, 0);
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;

        // Asynchronous reset with two words in flight.
        out_ready = 0;
        in_valid = 1; in_data = 8'hC1; step();
        in_data = 8'hC2; step();
        in_valid = 0; step();
        chk("t1_pre_out_valid", out_valid, 1);
        chk("t1_pre_occupancy", occupancy, 2);
        #2 rst = 1;
        #1;
        chk("t1_out_valid", out_valid, 0);
        chk("t1_occupancy", occupancy, 0);
        chk("t1_out_data", out_data, 0);
        chk("t1_in_ready", in_ready, 0);
        q.delete();
        @(negedge clk) rst = 0;
        @(posedge clk);
        #1;

        // Streaming with out_ready held high.
        add(1, 8'h11, 1, 0, 1, 0, 0, 8'h00);
        add(1, 8'h22, 1, 0, 1, 0, 1, 8'h00);
        add(1, 8'h33, 1, 0, 1, 0, 2, 8'h00);
        add(0, 8'h00, 1, 0, 1, 1, 3, 8'h11);
        add(0, 8'h00, 1, 0, 1, 1, 2, 8'h22);
        add(0, 8'h00, 1, 0, 1, 1, 1, 8'h33);
        add(0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        run_table("stream");

        // Back-pressure then release.
        add(1, 8'hA1, 0, 0, 1, 0, 0, 8'h00);
        add(1, 8'hA2, 0, 0, 1, 0, 1, 8'h00);
        add(1, 8'hA3, 0, 0, 1, 0, 2, 8'h00);
        add(1, 8'hA4, 0, 0, 0, 1, 3, 8'hA1);
        add(1, 8'hA4, 0, 0, 0, 1, 3, 8'hA1);
        add(1, 8'hA4, 1, 0, 1, 1, 3, 8'hA1);
        add(0, 8'h00, 1, 0, 1, 1, 3, 8'hA2);
        add(0, 8'h00, 1, 0, 1, 1, 2, 8'hA3);
        add(0, 8'h00, 1, 0, 1, 1, 1, 8'hA4);
        add(0, 8'h00, 1, 0, 1, 0, 0, 8'h00);
        run_table("bp");

        // Bubble collapse under stall, then flush of a full pipe.
        add(1, 8'h05, 0, 0, 1, 0, 0, 8'h00);
        add(0, 8'h00, 0, 0, 1, 0, 1, 8'h00);
        add(0, 8'h00, 0, 0, 1, 0, 1, 8'h00);
        add(1, 8'h06, 0, 0, 1, 1, 1, 8'h05);
        add(0, 8'h00, 0, 0, 1, 1, 2, 8'h05);
        add(1, 8'h07, 0, 0, 1, 1, 2, 8'h05);
        add(0, 8'h00, 0, 0, 0, 1, 3, 8'h05);
        add(1, 8'h77, 0, 1, 0, 1, 3, 8'h05);
        add(0, 8'h00, 0, 0, 1, 0, 0, 8'h00);
        run_table("bub");
        chk("flush_out_data", out_data, 0);
        out_ready = 1;
        repeat (3) begin
            step();
            chk("flush_idle_out_valid", out_valid, 0);
        end

        // Full pass-through at one word per cycle.
        out_ready = 0;
        in_valid  = 1;
        for (int i = 0; i < 3; i++) begin
            in_data = 8'h80 + 8'(i);
            step();
        end
        out_ready = 1;
        for (int i = 0; i < 10; i++) begin
            in_data = 8'h90 + 8'(i);
            #1;
            chk($sformatf("full%0d_in_ready", i), in_ready, 1);
            chk($sformatf("full%0d_occupancy", i), occupancy, 3);
            step();
        end
        in_valid = 0;
        repeat (4) step();
        chk("final_queue_empty", q.size(), 0);
        chk("final_occupancy", occupancy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/dff_pipe.md
Name: dff_pipe

Overview:
Parametrised successor to the single-bit D flip-flop: a DEPTH-stage, WIDTH-bit register pipeline with valid/ready flow control.
- Each stage is a bubble-collapsing register slice.
- Provides synchronous flush and an occupancy count.
- Used to retime datapaths between blocks while preserving back-pressure.

Parameters:
- WIDTH, 8: data width in bits (>=1).
- DEPTH, 3: number of register stages (>=1).
- RESET_VAL, 0: value loaded into every data register on reset and flush.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  reset, asynchronous, active-high.
- flush  input  1  synchronous clear of all stage valids.
- in_valid  input  1  upstream data valid.
- in_ready  output  1  pipeline can accept in_data this cycle.
- in_data  input  WIDTH  upstream data.
- out_valid  output  1  last stage holds valid data.
- out_ready  input  1  downstream accepts out_data this cycle.
- out_data  output  WIDTH  data of last stage.
- occupancy  output  $clog2(DEPTH+1)  number of valid stages.

Behaviour:
- Reset:
  - Asynchronous, active-high: rst=1 immediately clears all valid_i to 0, all data_i to RESET_VAL and occupancy to 0.
  - So out_valid=0, out_data=RESET_VAL and in_ready=0 while rst=1.
  - Reset release is synchronous to the next rising clk edge.
- Stage model (i = 0..DEPTH-1):
  - Each stage holds valid_i and data_i.
  - ready_i = !valid_i || ready_{i+1}; ready_DEPTH = out_ready.
  - Combinational ready chain; no skid buffers.
- Load rule at each edge:
  - If ready_i, stage i loads valid_{i-1} and data_{i-1}. Stage 0 loads in_valid and in_data.
  - Data registers update only when the incoming valid is 1 and ready_i is 1; otherwise data_i holds.
  - Bubbles collapse: an empty stage accepts even when downstream stalls.
- Handshake:
  - in_ready = ready_0 && !flush && !rst.
  - Upstream transfer occurs when in_valid && in_ready.
  - Downstream transfer occurs when out_valid && out_ready.
  - While out_valid=1 and out_ready=0, out_data and out_valid are held stable.
  - in_data is ignored when in_valid=0.
- Latency and throughput:
  - With out_ready held 1, a word accepted at edge k appears on out_valid/out_data after edge k+DEPTH-1, i.e. DEPTH cycles after in_valid is presented.
  - Throughput is 1 word/cycle.
- Occupancy: registered count of valid stages, updated every edge; range 0..DEPTH.
  - A full pipe (occupancy=DEPTH) with out_ready=0 has in_ready=0.
  - A full pipe with out_ready=1 accepts and emits in the same cycle; occupancy stays DEPTH.
- Flush:
  - flush=1 at an edge clears all valid_i to 0 and sets all data_i to RESET_VAL; occupancy becomes 0.
  - in_ready=0 during flush, so no input is accepted.
  - A downstream transfer in the flush cycle is still counted as delivered.
  - Flush takes priority over all loads.
- Simultaneous events: rst overrides flush; flush overrides in/out handshakes.
- DEPTH=1: a single registered slice; in_ready = !valid_0 || out_ready.
- No combinational path from in_valid/in_data to out_valid/out_data. The out_ready -> in_ready path is combinational by design.

Test Plan:
1. Reset: assert rst=1 mid-stream with 2 words in flight -> out_valid=0, occupancy=0 and out_data=RESET_VAL immediately, without waiting for a clk edge.
2. Streaming, WIDTH=8, DEPTH=3, out_ready=1: send 0x11, 0x22, 0x33 back-to-back -> out_data is 0x11, 0x22, 0x33 on consecutive cycles; first out_valid appears 3 cycles after 0x11 is presented; occupancy peaks at 3.
3. Back-pressure: hold out_ready=0 and send 0xA1..0xA4 -> first 3 are accepted; in_ready=0 when occupancy=3; out_data holds 0xA1. Release out_ready -> 0xA1, 0xA2, 0xA3, 0xA4 exit in order, with no loss or duplication.
4. Bubble collapse: send 0x05, idle 2 cycles, send 0x06, with out_ready=0 -> both stages fill; occupancy=2; in_ready stays 1 until occupancy=3.
5. Flush: with occupancy=3, pulse flush=1 together with in_valid=1 and in_data=0x77 -> next cycle occupancy=0 and out_valid=0; 0x77 is never output.
6. Full pass-through: occupancy=3, in_valid=1, out_ready=1 continuously for 10 cycles -> in_ready=1 and occupancy=3 throughout; 10 outputs appear in input order.
